// File: rtl/tensor_core_operand_loader_pkg.sv
// Shared types for the tensor core operand loader: element width, the 3x3
// matrix type, the opcode encoding and the two FSM state sets.
package tensor_core_pkg;

  localparam int DATA_WIDTH = 8;

  typedef logic signed [DATA_WIDTH-1:0] matrix3x3_t [3][3];

  typedef enum logic [2:0] {
    OP_MATMUL = 3'b000,
    OP_ADD    = 3'b001,
    OP_RELU   = 3'b010
  } opcode_e;

  typedef enum logic [1:0] {
    ING_HDR,
    ING_LOAD_A,
    ING_LOAD_B,
    ING_FULL
  } ingest_state_e;

  typedef enum logic [1:0] {
    CORE_IDLE,
    CORE_WE,
    CORE_START,
    CORE_RUN
  } core_state_e;

  // Only the three defined opcodes start a frame; 011..111 are rejected.
  function automatic logic is_legal_opcode(input logic [2:0] op);
    return (op <= 3'b010);
  endfunction

endpackage

// File: rtl/tensor_core_operand_loader_stage_buffer.sv
// Shadow store for one incoming frame: nine A and nine B elements, written
// one byte at a time at a row-major index (r*3+c). B can be cleared in one
// cycle for frames that carry no B matrix.
module operand_stage_buffer #(
  parameter int W = 8
) (
  input  logic         tensor_core_clock,
  input  logic         reset_in,
  input  logic         wr_en,
  input  logic         wr_sel_b,
  input  logic [3:0]   wr_idx,
  input  logic [W-1:0] wr_data,
  input  logic         zero_b,
  output logic [W-1:0] stage_a [9],
  output logic [W-1:0] stage_b [9]
);

  // Element writes; a B clear and an A write may land on the same edge.
  always_ff @(posedge tensor_core_clock or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < 9; i++) begin
        stage_a[i] <= '0;
        stage_b[i] <= '0;
      end
    end else begin
      if (zero_b) begin
        for (int i = 0; i < 9; i++) stage_b[i] <= '0;
      end
      if (wr_en) begin
        if (wr_sel_b) stage_b[wr_idx] <= wr_data;
        else          stage_a[wr_idx] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/tensor_core_operand_loader.sv
// Operand feeder for small_tensor_core: ingests a byte-serial frame
// (header, 9 A bytes, 9 B bytes), commits it to stable operand registers and
// sequences the core's write-enable / start pulses.
// Build option: TENSOR_LOADER_RELU_SHORT_FRAME_EN -- relu frames carry no B
// bytes and staging B is zero-filled instead.
//
// Ingest FSM
//   state      | meaning
//   ING_HDR    | waiting for a header byte
//   ING_LOAD_A | accepting A elements 0..8
//   ING_LOAD_B | accepting B elements 0..8
//   ING_FULL   | staging complete, waiting for the core FSM to take it
// Core FSM
//   state      | meaning
//   CORE_IDLE  | no pass in flight; commits staging when ingest is FULL
//   CORE_WE    | register-file write enable to the core
//   CORE_START | start pulse to the core, run timer loaded
//   CORE_RUN   | core computing; operands held until the timer expires
module tensor_core_operand_loader #(
  parameter int DATA_WIDTH  = 8,
  parameter int CORE_CYCLES = 5
) (
  input  logic                         tensor_core_clock,
  input  logic                         reset_in,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [DATA_WIDTH-1:0]        load_data,
  output logic signed [DATA_WIDTH-1:0] tensor_core_input1 [3][3],
  output logic signed [DATA_WIDTH-1:0] tensor_core_input2 [3][3],
  output logic [2:0]                   operation_select,
  output logic                         tensor_core_register_file_write_enable,
  output logic                         should_start_tensor_core,
  output logic                         core_done,
  output logic                         opcode_error
);
  import tensor_core_pkg::*;

  localparam int RUN_W = (CORE_CYCLES > 1) ? $clog2(CORE_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LOAD = RUN_W'(CORE_CYCLES - 1);

  ingest_state_e ing_state, ing_next;
  core_state_e   core_state, core_next;

  logic [3:0]       elem_cnt, elem_cnt_next;
  logic [2:0]       stage_op, stage_op_next;
  logic [RUN_W-1:0] run_cnt, run_cnt_next;
  logic             err_next, done_next;
  logic             xfer, handoff;
  logic             buf_wr, buf_sel_b, buf_zero_b;

  logic [DATA_WIDTH-1:0] stage_a [9];
  logic [DATA_WIDTH-1:0] stage_b [9];
  logic [DATA_WIDTH-1:0] out_a   [9];
  logic [DATA_WIDTH-1:0] out_b   [9];

  assign load_ready = (ing_state != ING_FULL) && !reset_in;
  assign xfer       = load_valid && load_ready;
  // Staging changes hands on the same edge the core leaves IDLE.
  assign handoff    = (ing_state == ING_FULL) && (core_state == CORE_IDLE);

  operand_stage_buffer #(.W(DATA_WIDTH)) u_stage (
    .tensor_core_clock (tensor_core_clock),
    .reset_in          (reset_in),
    .wr_en             (buf_wr),
    .wr_sel_b          (buf_sel_b),
    .wr_idx            (elem_cnt),
    .wr_data           (load_data),
    .zero_b            (buf_zero_b),
    .stage_a           (stage_a),
    .stage_b           (stage_b)
  );

  // Ingest next-state: header decode, element counting, staging writes.
  always_comb begin
    ing_next      = ing_state;
    elem_cnt_next = elem_cnt;
    stage_op_next = stage_op;
    err_next      = 1'b0;
    buf_wr        = 1'b0;
    buf_sel_b     = 1'b0;
    buf_zero_b    = 1'b0;
    case (ing_state)
      ING_HDR: begin
        if (xfer) begin
          if (is_legal_opcode(load_data[2:0])) begin
            stage_op_next = load_data[2:0];
            elem_cnt_next = 4'd0;
            ing_next      = ING_LOAD_A;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ING_LOAD_A: begin
        if (xfer) begin
          buf_wr = 1'b1;
          if (elem_cnt == 4'd8) begin
            elem_cnt_next = 4'd0;
`ifdef TENSOR_LOADER_RELU_SHORT_FRAME_EN
            if (stage_op == OP_RELU) begin
              buf_zero_b = 1'b1;
              ing_next   = ING_FULL;
            end else begin
              ing_next = ING_LOAD_B;
            end
`else
            ing_next = ING_LOAD_B;
`endif
          end else begin
            elem_cnt_next = elem_cnt + 4'd1;
          end
        end
      end
      ING_LOAD_B: begin
        if (xfer) begin
          buf_wr    = 1'b1;
          buf_sel_b = 1'b1;
          if (elem_cnt == 4'd8) begin
            elem_cnt_next = 4'd0;
            ing_next      = ING_FULL;
          end else begin
            elem_cnt_next = elem_cnt + 4'd1;
          end
        end
      end
      ING_FULL: begin
        if (handoff) ing_next = ING_HDR;
      end
      default: ing_next = ING_HDR;
    endcase
  end

  // Ingest state, byte counter, staged opcode and the error pulse.
  always_ff @(posedge tensor_core_clock or posedge reset_in) begin
    if (reset_in) begin
      ing_state    <= ING_HDR;
      elem_cnt     <= 4'd0;
      stage_op     <= 3'b000;
      opcode_error <= 1'b0;
    end else begin
      ing_state    <= ing_next;
      elem_cnt     <= elem_cnt_next;
      stage_op     <= stage_op_next;
      opcode_error <= err_next;
    end
  end

  // Core sequencing: WE, START, then a down-counted run window.
  always_comb begin
    core_next    = core_state;
    run_cnt_next = run_cnt;
    done_next    = 1'b0;
    tensor_core_register_file_write_enable = 1'b0;
    should_start_tensor_core               = 1'b0;
    case (core_state)
      CORE_IDLE: begin
        if (handoff) core_next = CORE_WE;
      end
      CORE_WE: begin
        tensor_core_register_file_write_enable = 1'b1;
        core_next = CORE_START;
      end
      CORE_START: begin
        should_start_tensor_core = 1'b1;
        run_cnt_next = RUN_LOAD;
        core_next    = CORE_RUN;
      end
      CORE_RUN: begin
        if (run_cnt == '0) begin
          done_next = 1'b1;
          core_next = CORE_IDLE;
        end else begin
          run_cnt_next = run_cnt - RUN_W'(1);
        end
      end
      default: core_next = CORE_IDLE;
    endcase
  end

  // Core state, run timer and the completion pulse (first IDLE cycle).
  always_ff @(posedge tensor_core_clock or posedge reset_in) begin
    if (reset_in) begin
      core_state <= CORE_IDLE;
      run_cnt    <= '0;
      core_done  <= 1'b0;
    end else begin
      core_state <= core_next;
      run_cnt    <= run_cnt_next;
      core_done  <= done_next;
    end
  end

  // Committed operands: loaded only when the core leaves IDLE.
  always_ff @(posedge tensor_core_clock or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < 9; i++) begin
        out_a[i] <= '0;
        out_b[i] <= '0;
      end
      operation_select <= 3'b000;
    end else if (handoff) begin
      out_a            <= stage_a;
      out_b            <= stage_b;
      operation_select <= stage_op;
    end
  end

  // Row-major unpacking of the committed operands onto the core's buses.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tensor_core_input1[r][c] = out_a[r*3+c];
        tensor_core_input2[r][c] = out_b[r*3+c];
      end
    end
  end

endmodule

// File: tb/tb_tensor_core_operand_loader.sv
// Directed bench for tensor_core_operand_loader. Cycle index cyc counts from 1;
// the cycle that follows transfer edge N has index N+1.
module tb_tensor_core_operand_loader;
  import tensor_core_pkg::*;

  localparam int CC = 24;

  logic       tensor_core_clock = 1'b0;
  logic       reset_in = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready;
  matrix3x3_t in1, in2;
  logic [2:0] op_sel;
  logic       we, st, done, err;

  tensor_core_operand_loader #(.DATA_WIDTH(8), .CORE_CYCLES(CC)) dut (
    .tensor_core_clock                      (tensor_core_clock),
    .reset_in                               (reset_in),
    .load_valid                             (load_valid),
    .load_ready                             (load_ready),
    .load_data                              (load_data),
    .tensor_core_input1                     (in1),
    .tensor_core_input2                     (in2),
    .operation_select                       (op_sel),
    .tensor_core_register_file_write_enable (we),
    .should_start_tensor_core               (st),
    .core_done                              (done),
    .opcode_error                           (err)
  );

  always #5 tensor_core_clock = ~tensor_core_clock;

  int cyc = 1;
  int we_cnt = 0, done_cnt = 0, err_cnt = 0;
  always @(posedge tensor_core_clock) begin
    cyc <= cyc + 1;
    if (we)   we_cnt   <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  int n_checks = 0, n_fail = 0;
  int last_xfer = 0;

  typedef struct packed {
    logic [7:0]      hdr;
    logic [8:0][7:0] a;
    logic [8:0][7:0] b;
    int              exp_op;
    int              exp_a00;
    int              exp_a12;
    int              exp_b22;
  } vec_t;
  vec_t tbl [2];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge tensor_core_clock);
  endtask

  task automatic send(input logic [7:0] b);
    int g = 0;
    load_valid = 1'b1;
    load_data  = b;
    while (!load_ready && g < 200) begin tick(); g++; end
    if (g >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: load_ready stuck at 0, expected 1");
    end
    tick();
    last_xfer  = cyc - 1;
    load_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [8:0][7:0] a,
                            input logic [8:0][7:0] b, input int nb);
    send(hdr);
    for (int i = 0; i < 9; i++) send(a[i]);
    for (int i = 0; i < nb; i++) send(b[i]);
  endtask

  task automatic wait_we();
    int g = 0;
    while (!we && g < 60) begin tick(); g++; end
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < CC + 60) begin tick(); g++; end
  endtask

  task automatic chk_mat(input string nm, input int which, input logic [8:0][7:0] e);
    int bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (which == 1) begin
        if (in1[i/3][i%3] !== e[i]) bad++;
      end else begin
        if (in2[i/3][i%3] !== e[i]) bad++;
      end
    end
    chk(nm, bad, 0);
  endtask

  function automatic logic [8:0][7:0] seq(input logic [7:0] s, input logic [7:0] step);
    logic [8:0][7:0] r;
    logic [7:0] v = s;
    for (int i = 0; i < 9; i++) begin r[i] = v; v = v + step; end
    return r;
  endfunction

  function automatic logic [8:0][7:0] ident();
    logic [8:0][7:0] r = '0;
    r[0] = 8'd1; r[4] = 8'd1; r[8] = 8'd1;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, e0, w0, d0;
    logic [8:0][7:0] zeros = '0;
    logic [8:0][7:0] btog;

    tbl[0].hdr = 8'h00; tbl[0].a = seq(8'd1, 8'd1); tbl[0].b = ident();
    tbl[0].exp_op = 0; tbl[0].exp_a00 = 1;  tbl[0].exp_a12 = 6; tbl[0].exp_b22 = 1;
    tbl[1].hdr = 8'hF9; tbl[1].a = seq(8'hFC, 8'd1); tbl[1].b = seq(8'd10, 8'd10);
    tbl[1].exp_op = 1; tbl[1].exp_a00 = -4; tbl[1].exp_a12 = 1; tbl[1].exp_b22 = 90;

    // Reset state.
    repeat (3) tick();
    reset_in = 1'b0;
    tick();
    chk("rst_ready", load_ready, 1);
    chk("rst_we", we, 0);
    chk("rst_start", st, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_op", op_sel, 0);
    chk_mat("rst_in1", 1, zeros);
    chk_mat("rst_in2", 2, zeros);

    // Illegal header 0x05, then nine more illegal headers: all rejected.
    e0 = err_cnt; w0 = we_cnt;
    send(8'h05);
    chk("err_pulse", err, 1);
    tick();
    chk("err_one_cycle", err, 0);
    send(8'h03); send(8'h04); send(8'h06); send(8'h07); send(8'h0B);
    send(8'h0C); send(8'h0D); send(8'h0E); send(8'h0F);
    repeat (3) tick();
    chk("err_count", err_cnt - e0, 10);
    chk("err_no_we", we_cnt - w0, 0);
    chk("err_ready", load_ready, 1);

    // Table-driven frames with latency checks.
    for (int k = 0; k < 2; k++) begin
      send_frame(tbl[k].hdr, tbl[k].a, tbl[k].b, 9);
      n = last_xfer;
      wait_we();
      chk("we_latency", cyc - n, 2);
      chk("op_commit", op_sel, tbl[k].exp_op);
      chk("a00", in1[0][0], tbl[k].exp_a00);
      chk("a12", in1[1][2], tbl[k].exp_a12);
      chk("b22", in2[2][2], tbl[k].exp_b22);
      chk_mat("mat_a", 1, tbl[k].a);
      chk_mat("mat_b", 2, tbl[k].b);
      tick();
      chk("start_pulse", st, 1);
      wait_done();
      chk("done_latency", cyc - n, 4 + CC);
      chk("op_held", op_sel, tbl[k].exp_op);
      tick();
      chk("done_one_cycle", done, 0);
    end

    // Long stall mid-A, then valid toggling through LOAD_B.
    send(8'h00);
    for (int i = 0; i < 5; i++) send(8'(i + 1));
    repeat (30) tick();
    chk("stall_ready", load_ready, 1);
    for (int i = 5; i < 9; i++) send(8'(i + 1));
    btog = seq(8'd1, 8'd1);
    btog[8] = 8'h80;
    for (int i = 0; i < 9; i++) begin send(btog[i]); tick(); end
    wait_we();
    chk("tog_b22", in2[2][2], -128);
    chk("tog_b10", in2[1][0], 4);
    chk("tog_a22", in1[2][2], 9);
    wait_done();
    tick();

    // Relu frame: header 0x0A carries opcode 010 with junk upper bits.
`ifdef TENSOR_LOADER_RELU_SHORT_FRAME_EN
    send_frame(8'h02, seq(8'hFC, 8'd1), zeros, 0);
    n = last_xfer;
    wait_we();
    chk("relu_we_latency", cyc - n, 2);
    chk("relu_op", op_sel, 2);
    chk("relu_a00", in1[0][0], -4);
    chk("relu_a22", in1[2][2], 4);
    chk_mat("relu_b_zero", 2, zeros);
`else
    send_frame(8'h0A, seq(8'hFC, 8'd1), seq(8'h11, 8'd1), 9);
    n = last_xfer;
    wait_we();
    chk("relu_we_latency", cyc - n, 2);
    chk("relu_op", op_sel, 2);
    chk("relu_a00", in1[0][0], -4);
    chk("relu_b22", in2[2][2], 25);
`endif
    wait_done();
    tick();

    // Back-to-back: second frame fills staging while the first pass runs.
    send_frame(8'h01, seq(8'd3, 8'd0), seq(8'hFF, 8'd0), 9);
    n1 = last_xfer;
    send_frame(8'h00, seq(8'd9, 8'hFF), seq(8'd2, 8'd0), 9);
    chk("refill_timing", last_xfer - n1, 20);
    while (cyc < n1 + 27) tick();
    chk("b2b_ready_low", load_ready, 0);
    chk("b2b_op_hold", op_sel, 1);
    chk("b2b_a00_hold", in1[0][0], 3);
    chk("b2b_b22_hold", in2[2][2], -1);
    tick();
    chk("b2b_done", done, 1);
    chk("b2b_op_at_done", op_sel, 1);
    tick();
    chk("b2b_we", we, 1);
    chk("b2b_op_new", op_sel, 0);
    chk("b2b_a00_new", in1[0][0], 9);
    chk("b2b_a22_new", in1[2][2], 1);
    chk("b2b_b11_new", in2[1][1], 2);
    wait_done();
    chk("b2b_done2_latency", cyc - n1, 55);
    tick();

    // Reset during RUN cycle 2 aborts the pass.
    send_frame(8'h01, seq(8'd5, 8'd1), seq(8'd1, 8'd1), 9);
    n = last_xfer;
    while (cyc < n + 5) tick();
    d0 = done_cnt;
    reset_in = 1'b1;
    #1;
    chk("rrst_op", op_sel, 0);
    chk("rrst_a11", in1[1][1], 0);
    chk_mat("rrst_in2", 2, zeros);
    chk("rrst_we", we, 0);
    chk("rrst_start", st, 0);
    repeat (2) tick();
    reset_in = 1'b0;
    tick();
    chk("rrst_ready", load_ready, 1);
    repeat (CC + 10) tick();
    chk("rrst_no_done", done_cnt - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
